// File: rtl/fb_pixel_writer_pkg.sv
// fb_pkg: frame geometry, the queued pixel record and the writer's run/clear state.
package fb_pkg;
    localparam int FB_WIDTH      = 160;
    localparam int FB_HEIGHT     = 120;
    localparam int FB_WORDS      = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDRW      = 16;
    localparam int FB_COLOR_BITS = 9;

    typedef struct packed {
        logic [FB_ADDRW-1:0]      addr;
        logic [FB_COLOR_BITS-1:0] color;
    } pixel_t;

    typedef enum logic {RUN, CLEAR} wr_state_t;

    // Row-major word address y*160 + x, built from shifts and wrapping at 16 bits.
    function automatic logic [FB_ADDRW-1:0] pixelAddr(input logic [FB_ADDRW-1:0] x,
                                                      input logic [FB_ADDRW-1:0] y);
        return (y << 7) + (y << 5) + x;
    endfunction
endpackage

// File: rtl/fb_pixel_writer_if.sv
// fb_pixel_writer_if: scanner draw stream, clear control and framebuffer write port of the pixel writer.
interface fb_pixel_writer_if;
    import fb_pkg::*;

    logic [31:0]              Draw_X;
    logic [31:0]              Draw_Y;
    logic [31:0]              Draw_Color;
    logic                     Enable_Draw;
    logic                     write_allow;
    logic                     clear_req;
    logic [FB_COLOR_BITS-1:0] clear_color;
    logic                     fb_we;
    logic [FB_ADDRW-1:0]      fb_addr;
    logic [FB_COLOR_BITS-1:0] fb_data;
    logic                     clearing;
    logic                     clear_done;
    logic [15:0]              drop_count;
    logic [15:0]              clip_count;

    modport master (
        output Draw_X, Draw_Y, Draw_Color, Enable_Draw, write_allow, clear_req, clear_color,
        input  fb_we, fb_addr, fb_data, clearing, clear_done, drop_count, clip_count
    );

    modport slave (
        input  Draw_X, Draw_Y, Draw_Color, Enable_Draw, write_allow, clear_req, clear_color,
        output fb_we, fb_addr, fb_data, clearing, clear_done, drop_count, clip_count
    );
endinterface

// File: rtl/fb_pixel_writer_fifo.sv
// pixel_fifo: synchronous FIFO of pixel_t with flush; a push while full is taken only alongside a pop.
module pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  pixel_t pushData_i,
    input  logic   pop_i,
    input  logic   flush_i,
    output pixel_t popData_o,
    output logic   full_o,
    output logic   empty_o
);
    localparam int PTRW = $clog2(DEPTH);
    localparam logic [PTRW:0] PTR_ONE = (PTRW+1)'(1);

    pixel_t        mem_q [DEPTH];
    logic [PTRW:0] wrPtr_q;
    logic [PTRW:0] rdPtr_q;
    logic          doPush;
    logic          doPop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty_o   = (wrPtr_q == rdPtr_q);
    assign full_o    = (wrPtr_q[PTRW] != rdPtr_q[PTRW]) &&
                       (wrPtr_q[PTRW-1:0] == rdPtr_q[PTRW-1:0]);
    assign doPop     = pop_i && !empty_o;
    assign doPush    = push_i && (!full_o || doPop);
    assign popData_o = mem_q[rdPtr_q[PTRW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
            if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush_i && !reset) mem_q[wrPtr_q[PTRW-1:0]] <= pushData_i;
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: queues scanner pixels as framebuffer word writes and sweeps full-frame clears.
// Build macro FB_WRITER_CLIP_EN enables rejection of off-frame pixels and the clip counter.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    fb_pixel_writer_if.slave  bus
);
    localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_WORDS - 1);

    wr_state_t                state_q;
    logic                     s1Valid_q;
    pixel_t                   s1Pix_q;
    logic [FB_COLOR_BITS-1:0] clearColor_q;
    logic [FB_ADDRW-1:0]      sweep_q;
    logic                     sweepDone_q;
    logic                     fbWe_q;
    logic [FB_ADDRW-1:0]      fbAddr_q;
    logic [FB_COLOR_BITS-1:0] fbData_q;
    logic                     clearDone_q;
    logic [15:0]              dropCount_q;

    pixel_t                   pix_d;
    logic [FB_ADDRW-1:0]      pixAddr_d;
    pixel_t                   fifoHead;
    logic                     fifoFull;
    logic                     fifoEmpty;
    logic                     isRun;
    logic                     startClear;
    logic                     popEn;
    logic                     pushEn;
    logic                     dropEn;
    logic                     inFrame;
    logic                     captureEn;
    logic                     unusedBits;

`ifdef FB_WRITER_CLIP_EN
    logic [15:0] clipCount_q;
    logic        clipEn;

    assign inFrame    = (bus.Draw_X < FB_WIDTH) && (bus.Draw_Y < FB_HEIGHT);
    assign pixAddr_d  = pixelAddr(bus.Draw_X[15:0], bus.Draw_Y[15:0]);
    assign clipEn     = bus.Enable_Draw && isRun && !startClear && !inFrame;
    assign unusedBits = ^bus.Draw_Color[31:FB_COLOR_BITS];
    assign bus.clip_count = clipCount_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clipCount_q <= '0;
        end else if (clipEn && clipCount_q != 16'hFFFF) begin
            clipCount_q <= clipCount_q + 16'd1;
        end
    end
`else
    assign inFrame    = 1'b1;
    assign pixAddr_d  = pixelAddr({8'b0, bus.Draw_X[7:0]}, {9'b0, bus.Draw_Y[6:0]});
    assign unusedBits = ^{bus.Draw_X[31:8], bus.Draw_Y[31:7], bus.Draw_Color[31:FB_COLOR_BITS]};
    assign bus.clip_count = '0;
`endif

    // A clear request wins the cycle: nothing pops, the stage pixel and FIFO are discarded uncounted.
    assign isRun      = (state_q == RUN);
    assign startClear = isRun && bus.clear_req;
    assign popEn      = isRun && !startClear && !fifoEmpty && bus.write_allow;
    assign pushEn     = s1Valid_q && !startClear && (!fifoFull || popEn);
    assign dropEn     = s1Valid_q && !startClear && fifoFull && !popEn;
    assign captureEn  = bus.Enable_Draw && isRun && !startClear && inFrame;
    assign pix_d      = '{addr: pixAddr_d, color: bus.Draw_Color[FB_COLOR_BITS-1:0]};

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (pushEn),
        .pushData_i (s1Pix_q),
        .pop_i      (popEn),
        .flush_i    (startClear),
        .popData_o  (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Valid_q   <= 1'b0;
            s1Pix_q     <= '0;
            dropCount_q <= '0;
        end else begin
            s1Valid_q <= captureEn;
            if (captureEn) s1Pix_q <= pix_d;
            if (dropEn && dropCount_q != 16'hFFFF) dropCount_q <= dropCount_q + 16'd1;
        end
    end

    // After the write to the last word, one extra cycle emits clear_done before RUN resumes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            clearColor_q <= '0;
            sweep_q      <= '0;
            sweepDone_q  <= 1'b0;
            fbWe_q       <= 1'b0;
            fbAddr_q     <= '0;
            fbData_q     <= '0;
            clearDone_q  <= 1'b0;
        end else begin
            fbWe_q      <= 1'b0;
            clearDone_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (bus.clear_req) begin
                        state_q      <= CLEAR;
                        clearColor_q <= bus.clear_color;
                        sweep_q      <= '0;
                        sweepDone_q  <= 1'b0;
                        fbAddr_q     <= '0;
                    end else if (popEn) begin
                        fbWe_q   <= 1'b1;
                        fbAddr_q <= fifoHead.addr;
                        fbData_q <= fifoHead.color;
                    end
                end
                CLEAR: begin
                    if (sweepDone_q) begin
                        state_q     <= RUN;
                        clearDone_q <= 1'b1;
                    end else if (bus.write_allow) begin
                        fbWe_q   <= 1'b1;
                        fbAddr_q <= sweep_q;
                        fbData_q <= clearColor_q;
                        sweep_q  <= sweep_q + 16'd1;
                        if (sweep_q == LAST_ADDR) sweepDone_q <= 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.fb_we      = fbWe_q;
    assign bus.fb_addr    = fbAddr_q;
    assign bus.fb_data    = fbData_q;
    assign bus.clearing   = (state_q == CLEAR);
    assign bus.clear_done = clearDone_q;
    assign bus.drop_count = dropCount_q;
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: directed stimulus for fb_pixel_writer, checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_fb_pixel_writer;
    import fb_pkg::*;

    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_pixel_writer_if bus();

    fb_pixel_writer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: pixels are (addr,color) pairs in a bounded queue; addresses come from y*160+x.
    typedef struct {
        int unsigned addr;
        int unsigned color;
    } mpix_t;

    mpix_t       mq[$];
    mpix_t       stPix;
    mpix_t       popPix;
    bit          stValid;
    bit          mClearing;
    bit          mFinishing;
    bit          wasClr;
    bit          startClr;
    bit          doPop;
    bit          modelReady;
    int unsigned clrNext;
    logic [8:0]  clrColor;
    logic        expWe;
    logic        expDone;
    logic        expClearing;
    logic [15:0] expAddr;
    logic [8:0]  expData;
    logic [15:0] expDrop;
    logic [15:0] expClip;

    function automatic bit modelInFrame(input logic [31:0] x, input logic [31:0] y);
`ifdef FB_WRITER_CLIP_EN
        return (x < 160) && (y < 120);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int unsigned modelAddr(input logic [31:0] x, input logic [31:0] y);
`ifdef FB_WRITER_CLIP_EN
        return (x + 160 * y) % 65536;
`else
        return ((x % 256) + 160 * (y % 128)) % 65536;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            stValid     = 1'b0;
            mClearing   = 1'b0;
            mFinishing  = 1'b0;
            clrNext     = 0;
            clrColor    = '0;
            expWe       = 1'b0;
            expDone     = 1'b0;
            expClearing = 1'b0;
            expAddr     = '0;
            expData     = '0;
            expDrop     = '0;
            expClip     = '0;
            modelReady  = 1'b1;
        end else begin
            wasClr   = mClearing;
            startClr = !wasClr && bus.clear_req;
            expWe    = 1'b0;
            expDone  = 1'b0;
            doPop    = !wasClr && !startClr && bus.write_allow && (mq.size() > 0);
            if (doPop) begin
                popPix  = mq.pop_front();
                expWe   = 1'b1;
                expAddr = 16'(popPix.addr);
                expData = 9'(popPix.color);
            end
            if (stValid && !startClr) begin
                if (mq.size() < FIFO_DEPTH) mq.push_back(stPix);
                else if (expDrop != 16'hFFFF) expDrop = expDrop + 16'd1;
            end
            if (startClr) mq.delete();
            stValid = 1'b0;
            if (!wasClr && !startClr && bus.Enable_Draw) begin
                if (modelInFrame(bus.Draw_X, bus.Draw_Y)) begin
                    stValid     = 1'b1;
                    stPix.addr  = modelAddr(bus.Draw_X, bus.Draw_Y);
                    stPix.color = bus.Draw_Color % 512;
                end else if (expClip != 16'hFFFF) begin
                    expClip = expClip + 16'd1;
                end
            end
            if (startClr) begin
                mClearing  = 1'b1;
                mFinishing = 1'b0;
                clrColor   = bus.clear_color;
                clrNext    = 0;
                expAddr    = '0;
            end else if (wasClr) begin
                if (mFinishing) begin
                    mClearing = 1'b0;
                    expDone   = 1'b1;
                end else if (bus.write_allow) begin
                    expWe   = 1'b1;
                    expAddr = 16'(clrNext);
                    expData = clrColor;
                    clrNext++;
                    if (clrNext == 19200) mFinishing = 1'b1;
                end
            end
            expClearing = mClearing;
        end
    end

    always @(negedge clk) begin
        if (modelReady) begin
            checkOutput("fb_we",      32'(bus.fb_we),      32'(expWe));
            checkOutput("fb_addr",    32'(bus.fb_addr),    32'(expAddr));
            checkOutput("fb_data",    32'(bus.fb_data),    32'(expData));
            checkOutput("clearing",   32'(bus.clearing),   32'(expClearing));
            checkOutput("clear_done", 32'(bus.clear_done), 32'(expDone));
            checkOutput("drop_count", 32'(bus.drop_count), 32'(expDrop));
            checkOutput("clip_count", 32'(bus.clip_count), 32'(expClip));
        end
    end

    task automatic driveInputs(input bit en, input int x, input int y, input int color,
                               input bit wa, input bit clr, input int cc);
        bus.Enable_Draw = en;
        bus.Draw_X      = x;
        bus.Draw_Y      = y;
        bus.Draw_Color  = color;
        bus.write_allow = wa;
        bus.clear_req   = clr;
        bus.clear_color = cc[8:0];
    endtask

    task automatic applyStimulus(input bit en, input int x, input int y, input int color,
                                 input bit wa, input bit clr, input int cc);
        @(negedge clk);
        driveInputs(en, x, y, color, wa, clr, cc);
    endtask

    task automatic pixelLatency(input string tag, input int x, input int y, input int color,
                                input int expA, input bit expWrite);
        applyStimulus(1, x, y, color, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput({tag, " c1 we"}, 32'(bus.fb_we), 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput({tag, " c2 we"}, 32'(bus.fb_we), 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput({tag, " c3 we"}, 32'(bus.fb_we), 32'(expWrite));
        if (expWrite) begin
            checkOutput({tag, " c3 addr"}, 32'(bus.fb_addr), expA);
            checkOutput({tag, " c3 data"}, 32'(bus.fb_data), color);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput({tag, " c4 we"}, 32'(bus.fb_we), 0);
    endtask

    initial begin
        bit          doneSeen;
        bit          hit;
        int          clrIdx;
        int          lastWriteIter;
        int          strayWrites;
        int          nWr;
        logic [15:0] lastA;

        reset = 1'b1;
        driveInputs(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("reset fb_we",      32'(bus.fb_we), 0);
        checkOutput("reset fb_addr",    32'(bus.fb_addr), 0);
        checkOutput("reset clearing",   32'(bus.clearing), 0);
        checkOutput("reset drop_count", 32'(bus.drop_count), 0);
        reset = 1'b0;
        repeat (2) applyStimulus(0, 0, 0, 0, 1, 0, 0);

        pixelLatency("basic", 5, 2, 'h1A5, 325, 1);

`ifdef FB_WRITER_CLIP_EN
        applyStimulus(1, 159, 119, 'h1F0, 1, 0, 0);
        applyStimulus(1, 160, 0,   'h1F1, 1, 0, 0);
        applyStimulus(1, 0,   120, 'h1F2, 1, 0, 0);
        nWr   = 0;
        lastA = '0;
        repeat (6) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            if (bus.fb_we) begin
                nWr++;
                lastA = bus.fb_addr;
            end
        end
        checkOutput("clip writes",     nWr, 1);
        checkOutput("clip corner addr", 32'(lastA), 19199);
        checkOutput("clip_count",       32'(bus.clip_count), 2);
`else
        pixelLatency("edge160", 160, 0, 'h033, 160, 1);
        pixelLatency("corner", 159, 119, 'h1F0, 19199, 1);
`endif

        for (int i = 0; i < 12; i++) applyStimulus(1, i, 0, 'h40 + i, 0, 0, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall drops", 32'(bus.drop_count), 4);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            checkOutput($sformatf("drain%0d we", k),   32'(bus.fb_we), 1);
            checkOutput($sformatf("drain%0d addr", k), 32'(bus.fb_addr), k);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("drain end we", 32'(bus.fb_we), 0);

        for (int i = 0; i < 8; i++) applyStimulus(1, 20 + i, 0, 'h60 + i, 0, 0, 0);
        repeat (2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1, 40 + j, 0, 'h80 + j, 1, 0, 0);
            if (j > 0) checkOutput($sformatf("full stream%0d we", j), 32'(bus.fb_we), 1);
        end
        repeat (12) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("full stream drops", 32'(bus.drop_count), 4);

        for (int i = 0; i < 5; i++) applyStimulus(1, 50 + i, 3, 'h100 + i, 1, 0, 0);
        applyStimulus(1, 55, 3, 'h105, 1, 1, 'h0F0);
        doneSeen      = 1'b0;
        clrIdx        = 0;
        lastWriteIter = -10;
        strayWrites   = 0;
        for (int i = 0; i < 21000 && !doneSeen; i++) begin
            @(negedge clk);
            if (bus.fb_we && bus.clearing) begin
                if (clrIdx < 3 || clrIdx > 19196 || bus.fb_addr != 16'(clrIdx) || bus.fb_data != 9'h0F0) begin
                    checkOutput($sformatf("clear write%0d addr", clrIdx), 32'(bus.fb_addr), clrIdx);
                    checkOutput($sformatf("clear write%0d data", clrIdx), 32'(bus.fb_data), 'h0F0);
                end
                clrIdx++;
                lastWriteIter = i;
            end else if (bus.fb_we) begin
                strayWrites++;
            end
            if (bus.clear_done) begin
                doneSeen = 1'b1;
                checkOutput("clear_done gap", i - lastWriteIter, 1);
            end
            driveInputs(1, i % 160, (i / 160) % 120, i, !(i >= 500 && i < 503), 0, 0);
        end
        checkOutput("clear write count", clrIdx, 19200);
        checkOutput("clear_done seen",   32'(doneSeen), 1);
        checkOutput("pixel writes during clear", strayWrites, 0);
        repeat (10) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("clear drops", 32'(bus.drop_count), 4);

        applyStimulus(0, 0, 0, 0, 1, 1, 'h155);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            driveInputs(0, 0, 0, 0, 1, 0, 0);
            if (bus.fb_we && bus.clearing && bus.fb_addr == 16'd100) begin
                hit   = 1'b1;
                reset = 1'b1;
            end
        end
        checkOutput("reset point reached", 32'(hit), 1);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort fb_we",      32'(bus.fb_we), 0);
        checkOutput("abort fb_addr",    32'(bus.fb_addr), 0);
        checkOutput("abort fb_data",    32'(bus.fb_data), 0);
        checkOutput("abort clearing",   32'(bus.clearing), 0);
        checkOutput("abort clear_done", 32'(bus.clear_done), 0);
        checkOutput("abort drop_count", 32'(bus.drop_count), 0);
        checkOutput("abort clip_count", 32'(bus.clip_count), 0);
        repeat (5) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            checkOutput("no done after abort", 32'(bus.clear_done), 0);
        end
        pixelLatency("post reset", 7, 1, 'h0AA, 167, 1);

        repeat (4) applyStimulus(0, 0, 0, 0, 1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
